key_conditioner: RTL and testbench

Front-end input conditioner for the DE1 push-buttons. It synchronizes and debounces the raw active-low KEY pins, then emits clean single-cycle press, release and hold events. It also produces the active-low `start_n` and `pause_n` strobes that feed the game-state controller's `start` and `pause` inputs. A press becomes exactly one low cycle on the strobe, never a level, so a held key cannot retrigger pause/unpause every clock.

---
 rtl/ddr_pkg.sv | 18 +
 rtl/key_debounce_fsm.sv | 167 ++++++++++++++++
 rtl/key_conditioner.sv | 56 +++++
 tb/tb_key_conditioner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DE1 front-end: key FSM state encoding and
// default timing constants for the key conditioner.
package ddr_pkg;

    localparam int CLOCK_HZ                = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms at 50 MHz
    localparam int DEFAULT_HOLD_CYCLES     = 50_000_000;  // 1 s at 50 MHz

    typedef enum logic [2:0] {
        KEY_LOCKOUT      = 3'd0,
        KEY_RELEASED     = 3'd1,
        KEY_PRESS_WAIT   = 3'd2,
        KEY_PRESSED      = 3'd3,
        KEY_HELD         = 3'd4,
        KEY_RELEASE_WAIT = 3'd5
    } key_state_t;

endpackage

// File: rtl/key_debounce_fsm.sv
// One push-button: 2-flop synchronizer, debounce/hold FSM and registered
// press/release/hold pulses. press_event is the unregistered next-state
// press decision so the parent can register strobes in the same cycle.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// LOCKOUT      | after reset; wait for DEBOUNCE_CYCLES consecutive releases
// RELEASED     | key debounced released, idle
// PRESS_WAIT   | counting consecutive low samples toward an accepted press
// PRESSED      | accepted press, hold counter running
// HELD         | hold pulse already fired for this press
// RELEASE_WAIT | counting consecutive high samples toward an accepted release
module key_debounce_fsm
    import ddr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic press_event
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic            sync1, sync2;
    logic            s;
    key_state_t      state, state_nx;
    logic [DW-1:0]   db_cnt, db_cnt_nx, db_cnt_inc;
    logic [HW-1:0]   hold_cnt, hold_cnt_nx, hold_cnt_inc;
    logic            held_flag, held_flag_nx;
    logic            release_nx, hold_nx, pressed_nx;

    assign s = sync2;
    // Saturating increments: counters stop at their terminal value, never wrap.
    assign db_cnt_inc   = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_ONE;
    assign hold_cnt_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_ONE;

    // Synchronize the raw pin; both stages idle at released (1).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Next-state, counter and pulse decisions for one key.
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        hold_cnt_nx  = hold_cnt;
        held_flag_nx = held_flag;
        press_event  = 1'b0;
        release_nx   = 1'b0;
        hold_nx      = 1'b0;
        case (state)
            KEY_LOCKOUT: begin
                if (!s) begin
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx  = KEY_RELEASED;
                    db_cnt_nx = '0;
                end else begin
                    db_cnt_nx = db_cnt_inc;
                end
            end
            KEY_RELEASED: begin
                if (!s) begin
                    state_nx  = KEY_PRESS_WAIT;
                    db_cnt_nx = DB_ONE;
                end
            end
            KEY_PRESS_WAIT: begin
                if (s) begin
                    state_nx  = KEY_RELEASED;
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx     = KEY_PRESSED;
                    db_cnt_nx    = '0;
                    hold_cnt_nx  = '0;
                    held_flag_nx = 1'b0;
                    press_event  = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt_inc;
                end
            end
            KEY_PRESSED: begin
                // The hold count advances even on the cycle a release
                // starts, so each RELEASE_WAIT cycle delays hold by one.
                hold_cnt_nx = hold_cnt_inc;
                if (hold_cnt == HOLD_LAST) begin
                    state_nx     = KEY_HELD;
                    held_flag_nx = 1'b1;
                    hold_nx      = 1'b1;
                end
                if (s) begin
                    state_nx  = KEY_RELEASE_WAIT;
                    db_cnt_nx = DB_ONE;
                end
            end
            KEY_HELD: begin
                if (s) begin
                    state_nx  = KEY_RELEASE_WAIT;
                    db_cnt_nx = DB_ONE;
                end
            end
            KEY_RELEASE_WAIT: begin
                if (!s) begin
                    state_nx  = held_flag ? KEY_HELD : KEY_PRESSED;
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx  = KEY_RELEASED;
                    db_cnt_nx = '0;
                    release_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt_inc;
                end
            end
            default: begin
                state_nx  = KEY_LOCKOUT;
                db_cnt_nx = '0;
            end
        endcase
    end

    assign pressed_nx = (state_nx == KEY_PRESSED) || (state_nx == KEY_HELD) ||
                        (state_nx == KEY_RELEASE_WAIT);

    // State, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= KEY_LOCKOUT;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            held_flag     <= 1'b0;
            key_pressed   <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            state         <= state_nx;
            db_cnt        <= db_cnt_nx;
            hold_cnt      <= hold_cnt_nx;
            held_flag     <= held_flag_nx;
            key_pressed   <= pressed_nx;
            press_pulse   <= press_event;
            release_pulse <= release_nx;
            hold_pulse    <= hold_nx;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// DE1 push-button front end: one debounce FSM per key plus the active-low
// single-cycle start/pause strobes for the game-state controller.
module key_conditioner
    import ddr_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int START_KEY       = 0,
    parameter int PAUSE_KEY       = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] hold_pulse,
    output logic                start_n,
    output logic                pause_n
);

    localparam logic [NUM_KEYS-1:0] START_SEL = NUM_KEYS'(1) << START_KEY;
    localparam logic [NUM_KEYS-1:0] PAUSE_SEL = NUM_KEYS'(1) << PAUSE_KEY;

    logic [NUM_KEYS-1:0] press_event;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_fsm (
            .clock        (clock),
            .reset        (reset),
            .key_n        (key_n[k]),
            .key_pressed  (key_pressed[k]),
            .press_pulse  (press_pulse[k]),
            .release_pulse(release_pulse[k]),
            .hold_pulse   (hold_pulse[k]),
            .press_event  (press_event[k])
        );
    end

    // Strobes share the press decision with press_pulse so they go low
    // in the same cycle rather than one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_n <= 1'b1;
            pause_n <= 1'b1;
        end else begin
            start_n <= ~|(press_event & START_SEL);
            pause_n <= ~|(press_event & PAUSE_SEL);
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity,
// every cycle compared against a run-length reference model.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int D  = 4;
    localparam int H  = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_pressed, press_pulse, release_pulse, hold_pulse;
    logic          start_n, pause_n;

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
        .START_KEY(0), .PAUSE_KEY(1)
    ) dut (
        .clock(clock), .reset(reset), .key_n(key_n),
        .key_pressed(key_pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .hold_pulse(hold_pulse),
        .start_n(start_n), .pause_n(pause_n)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: per key, a debounced level, an "armed" flag for the
    // post-reset lockout, the run length of samples disagreeing with the
    // level, and the number of pressed cycles counted toward hold.
    bit m_s1[NK], m_s2[NK], m_armed[NK], m_level[NK], m_hold_done[NK];
    int m_run[NK], m_hold[NK];
    bit e_press[NK], e_rel[NK], e_hold[NK];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_armed[k] = 0; m_level[k] = 0;
            m_hold_done[k] = 0; m_run[k] = 0; m_hold[k] = 0;
            e_press[k] = 0; e_rel[k] = 0; e_hold[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < NK; k++) begin
            bit v;
            v = m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = key_n[k];
            e_press[k] = 0; e_rel[k] = 0; e_hold[k] = 0;
            if (!m_armed[k]) begin
                if (v) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin m_armed[k] = 1; m_run[k] = 0; end
                end else m_run[k] = 0;
            end else if (!m_level[k]) begin
                if (!v) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_level[k] = 1; m_run[k] = 0; e_press[k] = 1;
                        m_hold[k] = 0; m_hold_done[k] = 0;
                    end
                end else m_run[k] = 0;
            end else begin
                if (m_run[k] == 0 && !m_hold_done[k]) begin
                    m_hold[k]++;
                    if (m_hold[k] == H) begin e_hold[k] = 1; m_hold_done[k] = 1; end
                end
                if (v) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin m_level[k] = 0; m_run[k] = 0; e_rel[k] = 1; end
                end else m_run[k] = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [NK-1:0] kp, pp, rp, hp;
        for (int k = 0; k < NK; k++) begin
            kp[k] = m_level[k]; pp[k] = e_press[k]; rp[k] = e_rel[k]; hp[k] = e_hold[k];
        end
        return {14'd0, kp, pp, rp, hp, ~e_press[0], ~e_press[1]};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {14'd0, key_pressed, press_pulse, release_pulse, hold_pulse, start_n, pause_n};
    endfunction

    // Event tallies taken from DUT outputs, cleared per scenario.
    int cyc = 0;
    int c_press[NK], c_rel[NK], c_hold[NK], t_press[NK], t_hold[NK];
    int c_start_low, c_pause_low, c_both;

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            c_press[k] = 0; c_rel[k] = 0; c_hold[k] = 0; t_press[k] = -1; t_hold[k] = -1;
        end
        c_start_low = 0; c_pause_low = 0; c_both = 0;
    endtask

    task automatic tick(input logic [NK-1:0] kn);
        key_n = kn;
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
        check("outputs", dut_vec(), model_vec());
        for (int k = 0; k < NK; k++) begin
            if (press_pulse[k])   begin c_press[k]++; t_press[k] = cyc; end
            if (release_pulse[k]) c_rel[k]++;
            if (hold_pulse[k])    begin c_hold[k]++; t_hold[k] = cyc; end
        end
        if (!start_n) c_start_low++;
        if (!pause_n) c_pause_low++;
        if (!start_n && !pause_n) c_both++;
        cyc++;
    endtask

    task automatic ticks(input int n, input logic [NK-1:0] kn);
        for (int i = 0; i < n; i++) tick(kn);
    endtask

    int c0, sl;
    logic [NK-1:0] rk;
    bit seen;

    initial begin
        reset = 1'b1;
        key_n = '1;
        model_reset();
        clear_counts();
        @(negedge clock);
        ticks(3, 4'hF);
        check("reset_values", dut_vec(), 32'h3);
        reset = 1'b0;
        ticks(10, 4'hF);

        // Clean press, hold and release on key 0.
        clear_counts();
        c0 = cyc;
        ticks(30, 4'b1110);
        check("clean_press_count", c_press[0], 1);
        check("clean_press_latency", t_press[0] - c0, D + 1);
        check("clean_start_low", c_start_low, 1);
        check("clean_hold_count", c_hold[0], 1);
        check("clean_hold_delay", t_hold[0] - t_press[0], H);
        check("clean_other_press", c_press[1] + c_press[2] + c_press[3], 0);
        ticks(10, 4'hF);
        check("clean_release_count", c_rel[0], 1);

        // Bounce on key 1.
        clear_counts();
        for (int r = 0; r < 5; r++) begin
            ticks(3, 4'b1101);
            tick(4'hF);
        end
        check("bounce_no_press", c_press[1], 0);
        sl = cyc;
        ticks(10, 4'b1101);
        check("bounce_press_count", c_press[1], 1);
        check("bounce_press_latency", t_press[1] - sl, D + 1);
        check("bounce_pause_low", c_pause_low, 1);
        ticks(10, 4'hF);

        // Key 1 held through reset.
        clear_counts();
        key_n = 4'b1101;
        reset = 1'b1;
        #1;
        check("reset_async", dut_vec(), 32'h3);
        model_reset();
        ticks(3, 4'b1101);
        reset = 1'b0;
        ticks(15, 4'b1101);
        check("held_reset_no_press", c_press[1], 0);
        ticks(8, 4'hF);
        ticks(10, 4'b1101);
        check("held_reset_repress", c_press[1], 1);
        ticks(10, 4'hF);

        // Simultaneous press on keys 0 and 1.
        clear_counts();
        ticks(12, 4'b1100);
        check("simul_both_low", c_both, 1);
        check("simul_start_low", c_start_low, 1);
        check("simul_pause_low", c_pause_low, 1);
        ticks(10, 4'hF);

        // Release glitch on key 2 while pressed.
        clear_counts();
        ticks(8, 4'b1011);
        ticks(2, 4'hF);
        ticks(20, 4'b1011);
        check("glitch_press_count", c_press[2], 1);
        check("glitch_no_release", c_rel[2], 0);
        check("glitch_hold_delay", t_hold[2] - t_press[2], H + 2);
        ticks(10, 4'hF);

        // Reset while a press pulse is high drops it immediately.
        clear_counts();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(4'b1110);
            if (press_pulse[0]) seen = 1;
        end
        check("midreset_press_seen", seen, 1);
        reset = 1'b1;
        #1;
        check("midreset_drop", dut_vec(), 32'h3);
        model_reset();
        ticks(2, 4'hF);
        reset = 1'b0;
        ticks(10, 4'hF);

        // Random key activity with occasional long stable stretches.
        rk = '1;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(11) == 0) rk[k] = ~rk[k];
            if (i == 400) begin
                reset = 1'b1;
                model_reset();
                ticks(2, rk);
                reset = 1'b0;
            end
            tick(rk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
